// File: rtl/opb_register_bank_simulink2ppc_pkg.sv
// Shared constants for the OPB register bank: CTRL layout, offsets and mode encoding.
// Also provides the CTRL read-value packer used by the read mux.
package opb_regbank_pkg;

    localparam int CTRL_OFFSET      = 0;
    localparam int CHAN_BASE_OFFSET = 1;

    localparam int SNAP_BIT  = 0;
    localparam int MODE_BIT  = 1;
    localparam int COUNT_LSB = 16;
    localparam int COUNT_W   = 16;

    typedef enum logic {
        MODE_LIVE = 1'b0,
        MODE_SNAP = 1'b1
    } mode_e;

    // SNAP_REQ always reads back as 0; only MODE and the count are visible.
    function automatic logic [31:0] ctrl_word(input logic [COUNT_W-1:0] count, input mode_e mode);
        logic [31:0] w;
        w = '0;
        w[COUNT_LSB +: COUNT_W] = count;
        w[MODE_BIT] = mode;
        return w;
    endfunction

endpackage

// File: rtl/opb_register_bank_simulink2ppc_if.sv
// OPB slave bundle: master drives address/data/control, slave returns read data and acks.
// Bit 0 is the MSB on every vector, matching OPB big-endian numbering.
interface opb_register_bank_simulink2ppc_if;
    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;

    modport master (
        output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );

    modport slave (
        input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );
endinterface

// File: rtl/opb_register_bank_simulink2ppc_decode.sv
// Generic OPB slave decode: window hit, word offset, one-shot ack and BE-qualified strobes.
// Ack is registered one cycle after the hit; the master holds the bus until ack, no stall beyond that.
module opb_slave_decode #(
    parameter int                      C_OPB_AWIDTH = 32,
    parameter logic [C_OPB_AWIDTH-1:0] C_BASEADDR   = 32'h01002200,
    parameter logic [C_OPB_AWIDTH-1:0] C_HIGHADDR   = 32'h010022FF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [C_OPB_AWIDTH-1:2] word_addr_i,
    input  logic                    select_i,
    input  logic                    rnw_i,
    input  logic [0:3]              be_i,
    output logic [C_OPB_AWIDTH-3:0] offset_o,
    output logic                    rd_stb_o,
    output logic [0:3]              wr_be_o,
    output logic                    ack_o
);

    localparam logic [C_OPB_AWIDTH-1:2] BASE_W = C_BASEADDR[C_OPB_AWIDTH-1:2];
    localparam logic [C_OPB_AWIDTH-1:2] HIGH_W = C_HIGHADDR[C_OPB_AWIDTH-1:2];

    logic hit;
    logic ack_q, ack_d;

    assign hit      = select_i && (word_addr_i >= BASE_W) && (word_addr_i <= HIGH_W);
    assign offset_o = word_addr_i - BASE_W;

    // Serving only when ack_q is low keeps a held select from being acked twice.
    assign ack_d    = hit && !ack_q;
    assign rd_stb_o = ack_d && rnw_i;
    assign wr_be_o  = {4{ack_d && !rnw_i}} & be_i;
    assign ack_o    = ack_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= ack_d;
        end
    end

endmodule

// File: rtl/opb_register_bank_simulink2ppc.sv
// N_CHAN read-only shadow words plus CTRL over OPB, with LIVE tracking or atomic SNAPSHOT capture.
// Read data and ack one cycle after the hit; never stalls; Sl_DBus is zero outside the ack cycle.
module opb_register_bank_simulink2ppc
    import opb_regbank_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h01002200,
    parameter logic [31:0] C_HIGHADDR   = 32'h010022FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter int          N_CHAN       = 4,
    parameter              C_FAMILY     = "virtex6"
) (
    input  logic                       OPB_Clk,
    input  logic                       OPB_Rst_n,
    opb_register_bank_simulink2ppc_if.slave bus,
    input  logic [N_CHAN*32-1:0]       user_data_in,
    input  logic                       user_capture,
    output logic                       capture_done
);

    localparam int OFF_W = C_OPB_AWIDTH - 2;

    logic [OFF_W-1:0]   offset;
    logic               rd_stb;
    logic [0:3]         wr_be;
    logic               ack;
    logic               ctrl_wr, snap_req, capture;

    logic [31:0]        shadow_q [N_CHAN];
    logic [31:0]        shadow_d [N_CHAN];
    mode_e              mode_q, mode_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               done_q;
    logic [31:0]        dbus_q, dbus_d;
    logic [31:0]        rdata;
    logic               unused_bits;

    opb_slave_decode #(
        .C_OPB_AWIDTH (C_OPB_AWIDTH),
        .C_BASEADDR   (C_BASEADDR),
        .C_HIGHADDR   (C_HIGHADDR)
    ) u_decode (
        .clk         (OPB_Clk),
        .rst_n       (OPB_Rst_n),
        .word_addr_i (bus.OPB_ABus[0:29]),
        .select_i    (bus.OPB_select),
        .rnw_i       (bus.OPB_RNW),
        .be_i        (bus.OPB_BE),
        .offset_o    (offset),
        .rd_stb_o    (rd_stb),
        .wr_be_o     (wr_be),
        .ack_o       (ack)
    );

    // CTRL's live bits all sit in the least-significant byte lane (BE[3], DBus[24:31]).
    assign ctrl_wr  = wr_be[3] && (offset == OFF_W'(CTRL_OFFSET));
    assign snap_req = ctrl_wr && bus.OPB_DBus[31 - SNAP_BIT];
    assign capture  = (mode_q == MODE_SNAP) && (user_capture || snap_req);

    always_comb begin
        mode_d  = mode_q;
        count_d = count_q + COUNT_W'(capture);
        if (ctrl_wr) begin
            mode_d = mode_e'(bus.OPB_DBus[31 - MODE_BIT]);
        end
        for (int k = 0; k < N_CHAN; k++) begin
            shadow_d[k] = shadow_q[k];
            if (mode_q == MODE_LIVE || capture) begin
                shadow_d[k] = user_data_in[32*k +: 32];
            end
        end
    end

    // Reads see register state as it stood in the hit cycle, before any same-edge capture.
    always_comb begin
        rdata = '0;
        if (offset == OFF_W'(CTRL_OFFSET)) begin
            rdata = ctrl_word(count_q, mode_q);
        end
        for (int k = 0; k < N_CHAN; k++) begin
            if (offset == OFF_W'(CHAN_BASE_OFFSET + k)) begin
                rdata = shadow_q[k];
            end
        end
        dbus_d = rd_stb ? rdata : '0;
    end

    always_ff @(posedge OPB_Clk) begin
        if (!OPB_Rst_n) begin
            for (int k = 0; k < N_CHAN; k++) begin
                shadow_q[k] <= '0;
            end
            mode_q  <= MODE_LIVE;
            count_q <= '0;
            done_q  <= 1'b0;
            dbus_q  <= '0;
        end else begin
            for (int k = 0; k < N_CHAN; k++) begin
                shadow_q[k] <= shadow_d[k];
            end
            mode_q  <= mode_d;
            count_q <= count_d;
            done_q  <= capture;
            dbus_q  <= dbus_d;
        end
    end

    assign bus.Sl_DBus    = dbus_q;
    assign bus.Sl_xferAck = ack;
    assign bus.Sl_errAck  = 1'b0;
    assign bus.Sl_retry   = 1'b0;
    assign bus.Sl_toutSup = 1'b0;
    assign capture_done   = done_q;

    assign unused_bits = ^{bus.OPB_seqAddr, bus.OPB_ABus[30:31], bus.OPB_DBus[0:29],
                           wr_be[0:2], C_OPB_DWIDTH, C_FAMILY};

endmodule

// File: tb/tb_opb_register_bank_simulink2ppc.sv
// Bench for the OPB register bank: scoreboard of expected read data popped on each ack.
module tb_opb_register_bank_simulink2ppc;

    localparam logic [31:0] BASE   = 32'h01002200;
    localparam logic [31:0] HIGH   = 32'h010022FF;
    localparam int          N_CHAN = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N_CHAN*32-1:0] user_data_in;
    logic                user_capture;
    logic                capture_done;

    opb_register_bank_simulink2ppc_if bus();

    opb_register_bank_simulink2ppc #(
        .C_BASEADDR   (BASE),
        .C_HIGHADDR   (HIGH),
        .C_OPB_AWIDTH (32),
        .C_OPB_DWIDTH (32),
        .N_CHAN       (N_CHAN),
        .C_FAMILY     ("virtex6")
    ) dut (
        .OPB_Clk      (clk),
        .OPB_Rst_n    (rst_n),
        .bus          (bus),
        .user_data_in (user_data_in),
        .user_capture (user_capture),
        .capture_done (capture_done)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          errors   = 0;
    int          done_cnt = 0;
    logic [31:0] exp_q[$];
    logic [15:0] m_count;
    logic        m_mode;

    always @(negedge clk) if (capture_done === 1'b1) done_cnt++;

    function automatic logic [31:0] ctrl_exp();
        return {m_count, 14'b0, m_mode, 1'b0};
    endfunction

    task automatic xfer(input logic [31:0] addr, input logic rnw, input logic [31:0] wdata,
                        input logic [3:0] be, input logic cap, input logic exp_ack, input string name);
        logic        got;
        logic [31:0] exp;
        @(posedge clk); #1;
        bus.OPB_ABus   = addr;
        bus.OPB_RNW    = rnw;
        bus.OPB_DBus   = rnw ? 32'h0 : wdata;
        bus.OPB_BE     = be;
        bus.OPB_select = 1'b1;
        user_capture   = cap;
        got = 1'b0;
        for (int i = 0; i < 16 && !got; i++) begin
            @(posedge clk); #1;
            user_capture = 1'b0;
            if (bus.Sl_xferAck === 1'b1) got = 1'b1;
        end
        checks++;
        if (got !== exp_ack) begin
            errors++;
            $display("FAIL %s ack: got %0b required %0b", name, got, exp_ack);
        end
        if (rnw && exp_ack) begin
            exp = exp_q.pop_front();
            if (got) begin
                checks++;
                if (bus.Sl_DBus !== exp) begin
                    errors++;
                    $display("FAIL %s data: got %08h required %08h", name, bus.Sl_DBus, exp);
                end
            end
        end
        if (got) begin
            // select is still high across the edge that closes the ack cycle
            @(posedge clk); #1;
            bus.OPB_select = 1'b0;
            checks++;
            if (bus.Sl_xferAck !== 1'b0 || bus.Sl_DBus !== 32'h0) begin
                errors++;
                $display("FAIL %s ack_len: ack %0b dbus %08h required 0 and 00000000",
                         name, bus.Sl_xferAck, bus.Sl_DBus);
            end
        end else begin
            bus.OPB_select = 1'b0;
            if (!exp_ack) begin
                checks++;
                if (bus.Sl_DBus !== 32'h0) begin
                    errors++;
                    $display("FAIL %s idle_dbus: got %08h required 00000000", name, bus.Sl_DBus);
                end
            end
        end
    endtask

    task automatic rd(input int off, input logic [31:0] exp, input logic cap, input string name);
        exp_q.push_back(exp);
        xfer(BASE + 32'(off * 4), 1'b1, 32'h0, 4'hF, cap, 1'b1, name);
    endtask

    task automatic wr(input int off, input logic [31:0] d, input logic [3:0] be,
                      input logic cap, input string name);
        xfer(BASE + 32'(off * 4), 1'b0, d, be, cap, 1'b1, name);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.Sl_xferAck !== 1'b0 || bus.Sl_DBus !== 32'h0 || capture_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: ack %0b dbus %08h done %0b required 0/00000000/0",
                     bus.Sl_xferAck, bus.Sl_DBus, capture_done);
        end
        rst_n   = 1'b1;
        m_count = 16'h0;
        m_mode  = 1'b0;
        for (int off = 0; off <= N_CHAN; off++) rd(off, 32'h0, 1'b0, "reset_rd");
    endtask

    task automatic test_live();
        user_data_in = {32'hDDDD0004, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001};
        rd(2, 32'hBBBB0002, 1'b0, "live_ch1");
        user_data_in[63:32] = 32'h5A5A1234;
        rd(2, 32'h5A5A1234, 1'b0, "live_ch1_new");
        rd(4, 32'hDDDD0004, 1'b0, "live_ch3");
        rd(0, ctrl_exp(), 1'b0, "live_ctrl");
    endtask

    task automatic test_capture_hw();
        int d0;
        wr(0, 32'h2, 4'hF, 1'b0, "mode_snap");
        m_mode = 1'b1;
        user_data_in = '0;
        rd(4, 32'hDDDD0004, 1'b0, "freeze_ch3");
        d0 = done_cnt;
        @(posedge clk); #1;
        user_data_in = {32'hDDDD0004, 32'hCCCC0003, 32'hBBBB0002, 32'h12345678};
        user_capture = 1'b1;
        @(posedge clk); #1;
        user_capture = 1'b0;
        user_data_in = '0;
        m_count = m_count + 16'd1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL hw_done: got %0d pulses required 1", done_cnt - d0);
        end
        rd(1, 32'h12345678, 1'b0, "hw_ch0");
        rd(2, 32'hBBBB0002, 1'b0, "hw_ch1");
        rd(0, ctrl_exp(), 1'b0, "hw_ctrl");
    endtask

    task automatic test_snap_both();
        int d0;
        d0 = done_cnt;
        user_data_in[31:0] = 32'hCAFE0001;
        wr(0, 32'h3, 4'hF, 1'b1, "snap_both");
        m_count = m_count + 16'd1;
        user_data_in = '0;
        rd(0, ctrl_exp(), 1'b0, "both_ctrl");
        rd(1, 32'hCAFE0001, 1'b0, "both_ch0");
        user_data_in[31:0] = 32'hBEEF0002;
        wr(0, 32'h3, 4'hF, 1'b0, "snap_req");
        m_count = m_count + 16'd1;
        rd(1, 32'hBEEF0002, 1'b0, "req_ch0");
        user_data_in[31:0] = 32'h0BAD0BAD;
        wr(0, 32'h3, 4'hE, 1'b0, "snap_be_lane");
        rd(1, 32'hBEEF0002, 1'b0, "be_lane_ch0");
        rd(0, ctrl_exp(), 1'b0, "be_lane_ctrl");
        checks++;
        if (done_cnt - d0 != 2) begin
            errors++;
            $display("FAIL both_done: got %0d pulses required 2", done_cnt - d0);
        end
    endtask

    task automatic test_count_wrap();
        int d0;
        int n;
        d0 = done_cnt;
        n  = 32'hFFFF - int'(m_count);
        @(posedge clk); #1;
        user_capture = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        user_capture = 1'b0;
        m_count = 16'hFFFF;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (done_cnt - d0 != n) begin
            errors++;
            $display("FAIL wrap_done: got %0d pulses required %0d", done_cnt - d0, n);
        end
        rd(0, ctrl_exp(), 1'b0, "ctrl_ffff");
        user_data_in[31:0] = 32'h0000F00D;
        wr(0, 32'h3, 4'hF, 1'b1, "wrap_both");
        m_count = m_count + 16'd1;
        rd(0, ctrl_exp(), 1'b0, "ctrl_wrap0");
    endtask

    task automatic test_capture_during_read();
        user_data_in[31:0] = 32'h77778888;
        rd(1, 32'h0000F00D, 1'b1, "cap_rd_old");
        m_count = m_count + 16'd1;
        rd(1, 32'h77778888, 1'b0, "cap_rd_new");
        rd(0, ctrl_exp(), 1'b0, "cap_rd_ctrl");
    endtask

    task automatic test_misc();
        wr(0, 32'h0, 4'hF, 1'b0, "mode_live");
        m_mode = 1'b0;
        user_data_in = {32'h44440004, 32'h33330003, 32'h22220002, 32'h11110001};
        rd(1, 32'h11110001, 1'b0, "resume_live");
        wr(0, 32'h2, 4'hE, 1'b0, "mode_be_lane");
        rd(0, ctrl_exp(), 1'b0, "mode_be_ctrl");
        user_data_in[31:0] = 32'h11112222;
        rd(1, 32'h11112222, 1'b0, "still_live");
        wr(3, 32'hFFFFFFFF, 4'hF, 1'b0, "wr_chan");
        rd(3, 32'h33330003, 1'b0, "chan_ro");
        rd(N_CHAN + 1, 32'h0, 1'b0, "past_chan");
        rd(N_CHAN + 2, 32'h0, 1'b0, "past_chan2");
        wr(N_CHAN + 2, 32'h12341234, 4'hF, 1'b0, "wr_past_chan");
        rd(63, 32'h0, 1'b0, "window_top");
        xfer(HIGH + 32'd4, 1'b1, 32'h0, 4'hF, 1'b0, 1'b0, "above_rd");
        xfer(HIGH + 32'd4, 1'b0, 32'h3, 4'hF, 1'b0, 1'b0, "above_wr");
        xfer(BASE - 32'd4, 1'b1, 32'h0, 4'hF, 1'b0, 1'b0, "below_rd");
        rd(0, ctrl_exp(), 1'b0, "ctrl_after_miss");
    endtask

    task automatic test_reset_mid();
        wr(0, 32'h2, 4'hF, 1'b0, "pre_rst_mode");
        m_mode = 1'b1;
        wr(0, 32'h3, 4'hF, 1'b0, "pre_rst_snap");
        m_count = m_count + 16'd1;
        rd(0, ctrl_exp(), 1'b0, "pre_rst_ctrl");
        user_data_in = '0;
        @(posedge clk); #1;
        bus.OPB_ABus   = BASE + 32'd4;
        bus.OPB_RNW    = 1'b1;
        bus.OPB_BE     = 4'hF;
        bus.OPB_select = 1'b1;
        rst_n          = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.Sl_xferAck !== 1'b0 || bus.Sl_DBus !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid: ack %0b dbus %08h required 0 and 00000000",
                     bus.Sl_xferAck, bus.Sl_DBus);
        end
        bus.OPB_select = 1'b0;
        @(posedge clk); #1;
        rst_n   = 1'b1;
        m_count = 16'h0;
        m_mode  = 1'b0;
        for (int off = 0; off <= N_CHAN; off++) rd(off, 32'h0, 1'b0, "post_rst");
    endtask

    initial begin
        rst_n           = 1'b0;
        user_data_in    = '0;
        user_capture    = 1'b0;
        bus.OPB_ABus    = 32'h0;
        bus.OPB_BE      = 4'h0;
        bus.OPB_DBus    = 32'h0;
        bus.OPB_RNW     = 1'b0;
        bus.OPB_select  = 1'b0;
        bus.OPB_seqAddr = 1'b0;
        m_count         = 16'h0;
        m_mode          = 1'b0;
        test_reset();
        test_live();
        test_capture_hw();
        test_snap_both();
        test_count_wrap();
        test_capture_during_read();
        test_misc();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/opb_register_bank_simulink2ppc.md
Name: opb_register_bank_simulink2ppc

Overview:
Parametrised successor to the single-word simulink2ppc register. It exposes N_CHAN 32-bit user words plus one control/status word to the PPC over OPB. It adds two modes: LIVE, where the shadow registers are resampled every cycle, and SNAPSHOT, where all channels are captured atomically on a hardware strobe or a software request. It sits on the OPB bus beside the other software registers. User logic and OPB share OPB_Clk, so there is no clock-domain crossing.

Parameters:
C_BASEADDR, 32'h01002200, first byte address of the window.
C_HIGHADDR, 32'h010022FF, last byte address of the window; must cover (N_CHAN+1)*4 bytes.
C_OPB_AWIDTH, 32, OPB address width.
C_OPB_DWIDTH, 32, OPB data width; only 32 is supported.
N_CHAN, 4, number of user words; legal range 1..63.
C_FAMILY, "virtex6", target family; passed through only.

Ports:
OPB_Clk  in  1  the single clock for the block.
OPB_Rst_n  in  1  reset; synchronous, active-low.
OPB_ABus  in  [0:31]  byte address.
OPB_BE  in  [0:3]  byte enables; BE[0] corresponds to DBus[0:7].
OPB_DBus  in  [0:31]  write data.
OPB_RNW  in  1  1 = read, 0 = write.
OPB_select  in  1  transfer request.
OPB_seqAddr  in  1  ignored.
Sl_DBus  out  [0:31]  read data.
Sl_xferAck  out  1  transfer acknowledge.
Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  tied to 0.
user_data_in  in  [N_CHAN*32-1:0]  channel k occupies bits [32k+31:32k].
user_capture  in  1  snapshot strobe; one cycle per capture.
capture_done  out  1  one-cycle pulse after each capture.

Behaviour:
- Reset (OPB_Rst_n = 0 at a rising edge):
  - shadow registers = 0, mode = LIVE (0), capture count = 0.
  - Sl_DBus = 0, Sl_xferAck = 0, capture_done = 0.
- Address map (word offset = (OPB_ABus - C_BASEADDR) >> 2):
  - Offset 0 = CTRL.
    - Bit 0 = SNAP_REQ: write-1 triggers a capture; self-clearing; reads as 0.
    - Bit 1 = MODE.
    - Bits [31:16] = capture count, read-only.
    - All other bits read as 0.
  - Offsets 1..N_CHAN = channel (offset-1) shadow register, read-only. Writes are acked and discarded.
  - Offsets above N_CHAN inside the window: reads return 0; writes are acked with no effect.
- Handshake:
  - A hit is OPB_select = 1 with the address inside [C_BASEADDR, C_HIGHADDR].
  - Sl_xferAck = hit AND NOT ack_q, registered. It is high for exactly one cycle, the cycle after the hit is sampled.
  - No re-ack while select stays high in the ack cycle.
  - Addresses outside the window get no response.
- Read data:
  - Sl_DBus is registered and carries the shadow or CTRL value as it stood in the hit cycle.
  - Sl_DBus is 0 in every non-ack cycle, so it can be wire-ORed onto the bus.
- Write to CTRL:
  - Takes effect on the ack edge.
  - MODE updates only if BE[3] = 1 (DBus[30] = bit 1).
  - SNAP_REQ is honoured only if BE[3] = 1 and DBus[31] = 1.
- LIVE mode (MODE = 0): every cycle, shadow[k] <= user_data_in[k]. user_capture and SNAP_REQ are ignored; the count does not change.
- SNAPSHOT mode (MODE = 1):
  - A capture event is user_capture = 1 or an accepted SNAP_REQ.
  - On the event edge, all shadows load user_data_in together and the count increments by 1.
  - capture_done is high in the following cycle.
  - user_capture and SNAP_REQ in the same cycle produce one capture and a count increment of 1.
- Count is 16 bits and wraps 0xFFFF -> 0x0000.
- A capture in the same cycle as a read hit: the read returns the pre-capture value, and the next read sees the new value.
- A write that switches MODE 1 -> 0 resumes tracking on the next cycle.
- A write that switches MODE 0 -> 1 freezes the shadows at the values loaded on that edge.
- Reset asserted mid-transfer: the ack is dropped, and Sl_DBus = 0 on the next edge.

Decomposition:
- Package opb_regbank_pkg:
  - CTRL_OFFSET = 0, CHAN_BASE_OFFSET = 1.
  - Bit indices SNAP_BIT = 0, MODE_BIT = 1, COUNT_LSB = 16, COUNT_W = 16.
  - Mode constants MODE_LIVE / MODE_SNAP.
- Sub-module opb_slave_decode: window hit, word offset, ack_q generation, and the BE-qualified write strobe. It is reusable by the other OPB register blocks.
- The top level holds the shadow array, CTRL, the capture logic and the read mux.

Test Plan:
- Reset, then read offsets 0..N_CHAN -> every read returns 0, each xferAck lasts exactly 1 cycle, and Sl_DBus = 0 outside the ack cycle.
- LIVE mode, N_CHAN=4, user_data_in = {32'hDDDD0004, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001}; read offset 2 -> 32'hBBBB0002. Change the input and read again -> the new value is returned.
- Write CTRL = 32'h2 (BE=4'hF), drive a user_capture pulse with channel0 = 32'h12345678, then change the input to 32'h0 -> offset 1 reads 32'h12345678, CTRL reads 32'h00010002, capture_done pulses once.
- SNAPSHOT mode: user_capture and a SNAP_REQ write (CTRL = 32'h3) in the same cycle -> count increments by exactly 1 and capture_done pulses once. Repeat from count 0xFFFF -> count reads 0x0000.
- Write CTRL = 32'h2 with BE = 4'hE -> MODE stays 0. Write to offset 3 -> acked, value unchanged. Read offset N_CHAN+2 inside the window -> 0. Access to C_HIGHADDR+4 -> no xferAck for 16 cycles.
- Assert OPB_Rst_n = 0 in the cycle between hit and ack -> xferAck is not asserted, and all registers read 0 after release.
